// File: rtl/regfile_wb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
// Shared types and widths for the register-file writeback path.
//   XLEN        : result data width
//   PREG_NUMBER : number of physical registers
//   PIDX_W      : physical register index width
//   wb_req_t    : one writeback result (destination preg + data)
// ----------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

    localparam int XLEN        = 32;
    localparam int PREG_NUMBER = 64;
    localparam int PIDX_W      = $clog2(PREG_NUMBER);

    typedef struct packed {
        logic [PIDX_W-1:0] pidx;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundles the FU completion handshakes and the two register-file write ports.
//   req_valid/req_pidx/req_data : per-FU result offer (flattened, FU i at slot i)
//   req_ready                   : per-FU holding buffer can accept
//   wra_* / wrb_*               : write ports A and B (also wakeup broadcast)
//   grant                       : buffers drained this cycle
//   occupancy                   : number of full holding buffers
// Modports: master = FU / regfile side, slave = arbiter.
// ----------------------------------------------------------------------------
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
    #(parameter int N_REQ = 4);

    localparam int OCC_W = $clog2(N_REQ + 1);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*PIDX_W-1:0] req_pidx;
    logic [N_REQ*XLEN-1:0]   req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    wra_en;
    logic [PIDX_W-1:0]       wra_idx;
    logic [XLEN-1:0]         wra_data;
    logic                    wrb_en;
    logic [PIDX_W-1:0]       wrb_idx;
    logic [XLEN-1:0]         wrb_data;
    logic [N_REQ-1:0]        grant;
    logic [OCC_W-1:0]        occupancy;

    modport master (
        output req_valid, req_pidx, req_data,
        input  req_ready, wra_en, wra_idx, wra_data,
        input  wrb_en, wrb_idx, wrb_data, grant, occupancy
    );

    modport slave (
        input  req_valid, req_pidx, req_data,
        output req_ready, wra_en, wra_idx, wra_data,
        output wrb_en, wrb_idx, wrb_data, grant, occupancy
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_pick2.sv
// ----------------------------------------------------------------------------
// rr_pick2
// Purely combinational round-robin picker granting up to two requesters.
//   req      : request vector
//   ptr      : index where the scan starts (wraps modulo N)
//   gnt_a    : one-hot first hit (zero when no request)
//   gnt_b    : one-hot second hit (zero when fewer than two requests)
//   last_idx : index of the last granted requester (ptr when none)
//   any      : at least one request present
// ----------------------------------------------------------------------------
module rr_pick2 #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt_a,
    output logic [N-1:0]     gnt_b,
    output logic [PTR_W-1:0] last_idx,
    output logic             any
);

    logic [1:0]       hits;
    logic [PTR_W-1:0] sel;

    always_comb begin
        gnt_a    = '0;
        gnt_b    = '0;
        last_idx = ptr;
        hits     = 2'd0;
        sel      = '0;
        for (int k = 0; k < N; k++) begin
            sel = PTR_W'((int'(ptr) + k) % N);
            if (req[sel]) begin
                if (hits == 2'd0) begin
                    gnt_a[sel] = 1'b1;
                    last_idx   = sel;
                    hits       = 2'd1;
                end else if (hits == 2'd1) begin
                    gnt_b[sel] = 1'b1;
                    last_idx   = sel;
                    hits       = 2'd2;
                end
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the register file's two write ports among N_REQ completing FUs.
// Each FU owns a 1-entry holding buffer filled over valid/ready; every cycle
// a round-robin scan drains up to two full buffers onto ports A and B.
//   clk   : clock
//   reset : synchronous, active-high; empties buffers, rr pointer to 0
//   flush : squash all buffered results (ports still drain this cycle)
//   bus   : regfile_wb_arbiter_if.slave (handshakes, write ports, status)
// ----------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
    #(parameter int N_REQ = 4) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    regfile_wb_arbiter_if.slave bus
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int OCC_W = $clog2(N_REQ + 1);

    wb_req_t              hold_p0 [N_REQ];
    logic [N_REQ-1:0]     full_p0;
    logic [PTR_W-1:0]     rr_ptr_p0;
    logic [OCC_W-1:0]     occ_p0;

    logic [N_REQ-1:0]     gnt_a, gnt_b, grant, ready, accept, full_nxt;
    logic [PTR_W-1:0]     last_idx;
    logic                 any_gnt;
    logic [OCC_W-1:0]     occ_nxt;
    wb_req_t              wra_sel, wrb_sel;

    rr_pick2 #(.N(N_REQ)) u_pick (
        .req      (full_p0),
        .ptr      (rr_ptr_p0),
        .gnt_a    (gnt_a),
        .gnt_b    (gnt_b),
        .last_idx (last_idx),
        .any      (any_gnt)
    );

    assign grant  = gnt_a | gnt_b;
    // A buffer being drained this cycle can be refilled in the same edge.
    assign ready  = {N_REQ{!flush}} & (~full_p0 | grant);
    assign accept = bus.req_valid & ready;

    // Port muxes are driven only from buffer state, so idle ports read zero.
    always_comb begin
        wra_sel = '0;
        wrb_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_a[i]) wra_sel = hold_p0[i];
            if (gnt_b[i]) wrb_sel = hold_p0[i];
        end
    end

    always_comb begin
        full_nxt = (full_p0 & ~grant) | accept;
        occ_nxt  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            occ_nxt = occ_nxt + OCC_W'(full_nxt[i]);
        end
    end

    // ---- stage p0: holding buffers and scheduler state ----
    always_ff @(posedge clk) begin
        if (reset) begin
            full_p0   <= '0;
            rr_ptr_p0 <= '0;
            occ_p0    <= '0;
        end else if (flush) begin
            full_p0   <= '0;
            occ_p0    <= '0;
        end else begin
            full_p0   <= full_nxt;
            occ_p0    <= occ_nxt;
            if (any_gnt) begin
                rr_ptr_p0 <= (last_idx == PTR_W'(N_REQ - 1)) ? '0 : last_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (accept[i]) begin
                hold_p0[i].pidx <= bus.req_pidx[i*PIDX_W +: PIDX_W];
                hold_p0[i].data <= bus.req_data[i*XLEN +: XLEN];
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.grant     = grant;
    assign bus.occupancy = occ_p0;
    assign bus.wra_en    = |gnt_a;
    assign bus.wra_idx   = wra_sel.pidx;
    assign bus.wra_data  = wra_sel.data;
    assign bus.wrb_en    = |gnt_b;
    assign bus.wrb_idx   = wrb_sel.pidx;
    assign bus.wrb_data  = wrb_sel.data;

    // Renaming guarantees distinct destinations on the two ports.
    a_dup_pidx: assert property (@(posedge clk) disable iff (reset)
        !(bus.wra_en && bus.wrb_en && (bus.wra_idx == bus.wrb_idx)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int N     = 4;
    localparam int OCC_W = $clog2(N + 1);

    logic clk = 1'b0;
    logic reset, flush;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.N_REQ(N)) bus();

    regfile_wb_arbiter #(.N_REQ(N)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    // stimulus presented by each FU
    logic [N-1:0]      in_valid;
    logic [PIDX_W-1:0] in_pidx [N];
    logic [XLEN-1:0]   in_data [N];

    // reference model: buffer contents and scan start
    bit                mfull [N];
    logic [PIDX_W-1:0] mpidx [N];
    logic [XLEN-1:0]   mdata [N];
    int                mptr;
    int                ea, eb;
    logic [N-1:0]      exp_grant, exp_ready;

    // regfile image built from the DUT write ports
    logic [XLEN-1:0]   rf   [PREG_NUMBER];
    int                wcnt [PREG_NUMBER];
    int                total_writes;

    int check_cnt = 0;
    int pass_cnt  = 0;

    function automatic int model_occ();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(mfull[i]);
        return c;
    endfunction

    // Apply inputs, let logic settle, derive expectations, log port writes.
    task automatic settle();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i] = in_valid[i];
            bus.req_pidx[i*PIDX_W +: PIDX_W] = in_pidx[i];
            bus.req_data[i*XLEN +: XLEN] = in_data[i];
        end
        #1;
        ea = -1;
        eb = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (mptr + k) % N;
            if (mfull[idx]) begin
                if (ea < 0) ea = idx;
                else if (eb < 0) eb = idx;
            end
        end
        exp_grant = '0;
        if (ea >= 0) exp_grant[ea] = 1'b1;
        if (eb >= 0) exp_grant[eb] = 1'b1;
        for (int i = 0; i < N; i++) exp_ready[i] = !flush && (!mfull[i] || exp_grant[i]);
        if (bus.wra_en === 1'b1) begin
            rf[bus.wra_idx] = bus.wra_data;
            wcnt[bus.wra_idx]++;
            total_writes++;
        end
        if (bus.wrb_en === 1'b1) begin
            rf[bus.wrb_idx] = bus.wrb_data;
            wcnt[bus.wrb_idx]++;
            total_writes++;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < N; i++) mfull[i] = 1'b0;
            mptr = 0;
        end else if (flush) begin
            for (int i = 0; i < N; i++) mfull[i] = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (exp_grant[i]) mfull[i] = 1'b0;
                if (in_valid[i] && exp_ready[i]) begin
                    mfull[i] = 1'b1;
                    mpidx[i] = in_pidx[i];
                    mdata[i] = in_data[i];
                end
            end
            if (eb >= 0) mptr = (eb + 1) % N;
            else if (ea >= 0) mptr = (ea + 1) % N;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b0;
        in_valid = '0;
        settle();
        advance();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush = 1'b0;
        in_valid = '0;
        settle(); advance();
        settle(); advance();
        reset = 1'b0;
        settle();
        check_cnt++; if (bus.wra_en !== 1'b0) $display("FAIL reset_wra_en: got %0b want 0", bus.wra_en); else pass_cnt++;
        check_cnt++; if (bus.wrb_en !== 1'b0) $display("FAIL reset_wrb_en: got %0b want 0", bus.wrb_en); else pass_cnt++;
        check_cnt++; if (bus.req_ready !== 4'b1111) $display("FAIL reset_ready: got %b want 1111", bus.req_ready); else pass_cnt++;
        check_cnt++; if (bus.occupancy !== '0) $display("FAIL reset_occ: got %0d want 0", bus.occupancy); else pass_cnt++;
        check_cnt++; if (bus.grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", bus.grant); else pass_cnt++;
        check_cnt++; if ({bus.wra_idx, bus.wra_data} !== '0) $display("FAIL reset_idle_port: got %h/%h want 0/0", bus.wra_idx, bus.wra_data); else pass_cnt++;
        advance();
    endtask

    task automatic test_single();
        do_reset();
        in_valid = 4'b0100;
        in_pidx[2] = 6'd17;
        in_data[2] = 32'hDEAD;
        settle();
        check_cnt++; if (bus.req_ready[2] !== 1'b1) $display("FAIL single_ready: got %0b want 1", bus.req_ready[2]); else pass_cnt++;
        advance();
        in_valid = '0;
        settle();
        check_cnt++; if (bus.wra_en !== 1'b1) $display("FAIL single_wra_en: got %0b want 1", bus.wra_en); else pass_cnt++;
        check_cnt++; if (bus.wra_idx !== 6'd17) $display("FAIL single_wra_idx: got %0d want 17", bus.wra_idx); else pass_cnt++;
        check_cnt++; if (bus.wra_data !== 32'hDEAD) $display("FAIL single_wra_data: got %h want dead", bus.wra_data); else pass_cnt++;
        check_cnt++; if (bus.wrb_en !== 1'b0) $display("FAIL single_wrb_en: got %0b want 0", bus.wrb_en); else pass_cnt++;
        check_cnt++; if (bus.grant !== 4'b0100) $display("FAIL single_grant: got %b want 0100", bus.grant); else pass_cnt++;
        advance();
        // rr pointer is now 3: FU3 must win port A over FU0
        in_valid = 4'b1001;
        in_pidx[0] = 6'd5;  in_data[0] = 32'h5555;
        in_pidx[3] = 6'd6;  in_data[3] = 32'h6666;
        settle(); advance();
        in_valid = '0;
        settle();
        check_cnt++; if (bus.wra_idx !== 6'd6 || bus.wrb_idx !== 6'd5) $display("FAIL single_rrptr: got A=%0d B=%0d want A=6 B=5", bus.wra_idx, bus.wrb_idx); else pass_cnt++;
        advance();
        settle(); advance();
    endtask

    task automatic test_contention();
        do_reset();
        in_valid = 4'b1111;
        for (int i = 0; i < N; i++) begin
            in_pidx[i] = PIDX_W'(20 + i);
            in_data[i] = 32'h1000 + i;
        end
        settle(); advance();
        in_valid = '0;
        settle();
        check_cnt++; if (bus.wra_idx !== 6'd20 || bus.wrb_idx !== 6'd21 || bus.wrb_data !== 32'h1001) $display("FAIL cont_t1_ports: got A=%0d B=%0d/%h want A=20 B=21/1001", bus.wra_idx, bus.wrb_idx, bus.wrb_data); else pass_cnt++;
        check_cnt++; if (bus.grant !== 4'b0011) $display("FAIL cont_t1_grant: got %b want 0011", bus.grant); else pass_cnt++;
        check_cnt++; if (bus.req_ready !== 4'b0011) $display("FAIL cont_t1_ready: got %b want 0011", bus.req_ready); else pass_cnt++;
        advance();
        settle();
        check_cnt++; if (bus.wra_idx !== 6'd22 || bus.wrb_idx !== 6'd23) $display("FAIL cont_t2_ports: got A=%0d B=%0d want A=22 B=23", bus.wra_idx, bus.wrb_idx); else pass_cnt++;
        check_cnt++; if (bus.grant !== 4'b1100) $display("FAIL cont_t2_grant: got %b want 1100", bus.grant); else pass_cnt++;
        advance();
        settle();
        check_cnt++; if (bus.wra_en !== 1'b0 || bus.wrb_en !== 1'b0 || bus.occupancy !== '0) $display("FAIL cont_t3_idle: got en=%b%b occ=%0d want 00 0", bus.wra_en, bus.wrb_en, bus.occupancy); else pass_cnt++;
        advance();
    endtask

    task automatic test_fairness();
        int done_cyc [N];
        int last_g0, max_gap, next0;
        logic [N-1:0] acc;
        do_reset();
        in_valid = 4'b1111;
        next0 = 40;
        in_pidx[0] = PIDX_W'(next0); in_data[0] = $urandom;
        for (int j = 1; j < N; j++) begin
            in_pidx[j] = PIDX_W'(10 + j);
            in_data[j] = $urandom;
            done_cyc[j] = -1;
        end
        last_g0 = 0;
        max_gap = 0;
        for (int c = 0; c < 10; c++) begin
            settle();
            for (int j = 1; j < N; j++) if (bus.grant[j] === 1'b1 && done_cyc[j] < 0) done_cyc[j] = c;
            if (bus.grant[0] === 1'b1) begin
                if (c - last_g0 > max_gap) max_gap = c - last_g0;
                last_g0 = c;
            end
            acc = in_valid & bus.req_ready;
            advance();
            if (acc[0]) begin
                next0++;
                in_pidx[0] = PIDX_W'(next0);
                in_data[0] = $urandom;
            end
            for (int j = 1; j < N; j++) if (acc[j]) in_valid[j] = 1'b0;
        end
        if (10 - last_g0 > max_gap) max_gap = 10 - last_g0;
        for (int j = 1; j < N; j++) begin
            check_cnt++; if (done_cyc[j] < 1 || done_cyc[j] > 2) $display("FAIL fair_fu%0d_written: got cycle %0d want 1..2", j, done_cyc[j]); else pass_cnt++;
        end
        check_cnt++; if (max_gap > 2) $display("FAIL fair_fu0_starve: got gap %0d want <=2", max_gap); else pass_cnt++;
        in_valid = '0;
        settle(); advance();
        settle(); advance();
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 4'b1010;
        in_pidx[1] = 6'd31; in_data[1] = 32'h3131;
        in_pidx[3] = 6'd33; in_data[3] = 32'h3333;
        settle(); advance();
        flush = 1'b1;
        in_valid = 4'b1111;
        for (int i = 0; i < N; i++) in_pidx[i] = PIDX_W'(40 + i);
        settle();
        check_cnt++; if (bus.wra_en !== 1'b1 || bus.wra_idx !== 6'd31 || bus.wra_data !== 32'h3131) $display("FAIL flush_port_a: got %b/%0d/%h want 1/31/3131", bus.wra_en, bus.wra_idx, bus.wra_data); else pass_cnt++;
        check_cnt++; if (bus.wrb_en !== 1'b1 || bus.wrb_idx !== 6'd33) $display("FAIL flush_port_b: got %b/%0d want 1/33", bus.wrb_en, bus.wrb_idx); else pass_cnt++;
        check_cnt++; if (bus.req_ready !== 4'b0000) $display("FAIL flush_ready: got %b want 0000", bus.req_ready); else pass_cnt++;
        check_cnt++; if (bus.occupancy !== OCC_W'(2)) $display("FAIL flush_occ_before: got %0d want 2", bus.occupancy); else pass_cnt++;
        advance();
        flush = 1'b0;
        in_valid = '0;
        settle();
        check_cnt++; if (bus.occupancy !== '0) $display("FAIL flush_occ_after: got %0d want 0", bus.occupancy); else pass_cnt++;
        check_cnt++; if (bus.wra_en !== 1'b0 || bus.wrb_en !== 1'b0 || bus.grant !== '0) $display("FAIL flush_no_write: got en=%b%b grant=%b want 00 0000", bus.wra_en, bus.wrb_en, bus.grant); else pass_cnt++;
        advance();
    endtask

    task automatic test_throughput();
        logic [XLEN-1:0] sent [40];
        int sent0, sent1;
        logic [N-1:0] acc;
        do_reset();
        for (int p = 0; p < PREG_NUMBER; p++) begin
            wcnt[p] = 0;
            rf[p] = '0;
        end
        total_writes = 0;
        for (int p = 0; p < 40; p++) sent[p] = $urandom;
        sent0 = 0;
        sent1 = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = {2'b00, sent1 < 20, sent0 < 20};
            in_pidx[0] = PIDX_W'(2 * sent0);     in_data[0] = sent[(2 * sent0) % 40];
            in_pidx[1] = PIDX_W'(2 * sent1 + 1); in_data[1] = sent[(2 * sent1 + 1) % 40];
            settle();
            acc = in_valid & bus.req_ready;
            advance();
            if (acc[0]) sent0++;
            if (acc[1]) sent1++;
        end
        in_valid = '0;
        for (int c = 0; c < 3; c++) begin
            settle(); advance();
        end
        check_cnt++; if (sent0 != 20 || sent1 != 20) $display("FAIL thru_accept_rate: got %0d/%0d want 20/20", sent0, sent1); else pass_cnt++;
        check_cnt++; if (total_writes != 40) $display("FAIL thru_total_writes: got %0d want 40", total_writes); else pass_cnt++;
        for (int p = 0; p < 40; p++) begin
            check_cnt++;
            if (wcnt[p] != 1 || rf[p] !== sent[p]) $display("FAIL thru_rf[%0d]: got cnt=%0d data=%h want cnt=1 data=%h", p, wcnt[p], rf[p], sent[p]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        int ctr;
        logic [N-1:0] acc;
        do_reset();
        ctr = 0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!in_valid[i] && $urandom_range(0, 1) == 1) begin
                    in_valid[i] = 1'b1;
                    in_pidx[i] = PIDX_W'(ctr % PREG_NUMBER);
                    in_data[i] = $urandom;
                    ctr++;
                end
            end
            flush = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 63) == 0);
            settle();
            check_cnt++;
            if ({bus.wra_en, bus.wra_idx, bus.wra_data} !== {ea >= 0, ea >= 0 ? mpidx[ea] : 6'd0, ea >= 0 ? mdata[ea] : 32'd0})
                $display("FAIL rand_port_a c%0d: got %b/%0d/%h want fu%0d", c, bus.wra_en, bus.wra_idx, bus.wra_data, ea);
            else pass_cnt++;
            check_cnt++;
            if ({bus.wrb_en, bus.wrb_idx, bus.wrb_data} !== {eb >= 0, eb >= 0 ? mpidx[eb] : 6'd0, eb >= 0 ? mdata[eb] : 32'd0})
                $display("FAIL rand_port_b c%0d: got %b/%0d/%h want fu%0d", c, bus.wrb_en, bus.wrb_idx, bus.wrb_data, eb);
            else pass_cnt++;
            check_cnt++;
            if (bus.grant !== exp_grant || bus.req_ready !== exp_ready)
                $display("FAIL rand_grant_ready c%0d: got %b/%b want %b/%b", c, bus.grant, bus.req_ready, exp_grant, exp_ready);
            else pass_cnt++;
            check_cnt++;
            if (bus.occupancy !== OCC_W'(model_occ()))
                $display("FAIL rand_occ c%0d: got %0d want %0d", c, bus.occupancy, model_occ());
            else pass_cnt++;
            acc = in_valid & bus.req_ready;
            advance();
            in_valid = in_valid & ~acc;
        end
        reset = 1'b0;
        flush = 1'b0;
        in_valid = '0;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        in_valid = '0;
        mptr = 0;
        total_writes = 0;
        for (int i = 0; i < N; i++) begin
            in_pidx[i] = '0;
            in_data[i] = '0;
            mfull[i] = 1'b0;
            mpidx[i] = '0;
            mdata[i] = '0;
        end
        for (int p = 0; p < PREG_NUMBER; p++) begin
            rf[p] = '0;
            wcnt[p] = 0;
        end
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_flush();
        test_throughput();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
